// File: rtl/ahb_defs.sv
// Shared AHB encodings (transfer type, response, transfer size) used by
// both the bus masters and the slaves of this subsystem.
package ahb_defs;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1,
        HRESP_RETRY = 2'd2,
        HRESP_SPLIT = 2'd3
    } hresp_e;

    typedef enum logic [1:0] {
        HSIZE_BYTE  = 2'd0,
        HSIZE_HALF  = 2'd1,
        HSIZE_WORD  = 2'd2,
        HSIZE_DWORD = 2'd3
    } hsize_e;

    // True when the transfer type carries a real transfer.
    function automatic logic htrans_active(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Byte-writable storage array: synchronous per-byte write, asynchronous read.
// Contents are never reset.
module ahb_slave_ram #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic              clk_i,
    input  logic [DW/8-1:0]   we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DW-1:0]     wdata_i,
    output logic [DW-1:0]     rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    // Write only the enabled byte lanes; untouched lanes keep their value.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DW/8; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_slave_sram.sv
// AHB-Lite SRAM slave: address-phase decode and error check, optional
// fixed wait states, two-cycle ERROR response, byte-lane writes.
module ahb_slave_sram
    import ahb_defs::*;
#(
    parameter int BUS_WDT     = 32,
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic               i_hclk,
    input  logic               i_hreset_n,
    input  logic               i_hsel,
    input  logic [31:0]        i_haddr,
    input  logic [1:0]         i_htrans,
    input  logic               i_hwrite,
    input  logic [1:0]         i_hsize,
    input  logic [BUS_WDT-1:0] i_hwdata,
    input  logic               i_hready,
    output logic               o_hready,
    output logic [1:0]         o_hresp,
    output logic [BUS_WDT-1:0] o_hrdata
);

    localparam int          NB    = BUS_WDT / 8;
    localparam int          LSB   = $clog2(NB);
    localparam int          IDX_W = MEM_AW + LSB;
    localparam logic [1:0]  WS    = 2'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic [IDX_W-1:0]  addr_q;
    logic              write_q;
    logic [1:0]        size_q;

    logic              accept;
    logic              err_in;
    logic              complete;
    logic [NB-1:0]     byte_we;
    logic [BUS_WDT-1:0] ram_rdata;

    // Out of range, misaligned for its size, or wider than the bus.
    function automatic logic addr_err(input logic [31:0] a, input logic [1:0] sz);
        logic oor, mis, big;
        oor = (a >> IDX_W) != 32'd0;
        big = int'(sz) > LSB;
        case (sz)
            HSIZE_BYTE: mis = 1'b0;
            HSIZE_HALF: mis = a[0];
            HSIZE_WORD: mis = |a[1:0];
            default:    mis = |a[2:0];
        endcase
        return oor | mis | big;
    endfunction

    // Lanes covered by a transfer of size sz starting at byte offset off.
    function automatic logic [NB-1:0] byte_en(input logic [LSB-1:0] off, input logic [1:0] sz);
        logic [NB-1:0] base;
        case (sz)
            HSIZE_BYTE: base = NB'(1);
            HSIZE_HALF: base = NB'(3);
            HSIZE_WORD: base = NB'(15);
            default:    base = NB'(255);
        endcase
        return base << off;
    endfunction

    assign o_hready = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign o_hresp  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign accept   = i_hsel && i_hready && o_hready && htrans_active(i_htrans);
    assign err_in   = addr_err(i_haddr, i_hsize);
    // A legal data phase finishes in the first IDLE cycle it sees.
    assign complete = vld_q && (state_q == ST_IDLE);
    assign byte_we  = (complete && write_q) ? byte_en(addr_q[LSB-1:0], size_q) : '0;
    assign o_hrdata = (vld_q && !write_q) ? ram_rdata : '0;

    // Control state: FSM, wait counter and data-phase valid.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

    // Address-phase attributes, captured whenever a transfer is accepted.
    always_ff @(posedge i_hclk) begin
        if (accept) begin
            addr_q  <= i_haddr[IDX_W-1:0];
            write_q <= i_hwrite;
            size_q  <= i_hsize;
        end
    end

    // Next-state logic: accept in IDLE/ERR2, count down in WAIT, ERR1 -> ERR2.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        if (complete) begin
            vld_d = 1'b0;
        end
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (err_in) begin
                        state_d = ST_ERR1;
                    end else begin
                        vld_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = ST_WAIT;
                            cnt_d   = WS;
                        end
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_ERR2;
            end
        endcase
    end

    ahb_slave_ram #(
        .DW (BUS_WDT),
        .AW (MEM_AW)
    ) u_ram (
        .clk_i   (i_hclk),
        .we_i    (byte_we),
        .addr_i  (addr_q[IDX_W-1:LSB]),
        .wdata_i (i_hwdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_ahb_slave_sram.sv
// Bench for ahb_slave_sram: one zero-wait and one two-wait instance share
// the address/data bus and are selected individually.
module tb_ahb_slave_sram;

    logic        clk;
    logic        rst_n;
    logic        sel0, sel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [1:0]  hsize;
    logic [31:0] hwdata;
    logic        hready0, hready2;
    logic [1:0]  hresp0, hresp2;
    logic [31:0] hrdata0, hrdata2;

    int checks = 0;
    int errors = 0;

    // Byte-addressed reference memories, index 0 = zero-wait, 1 = two-wait.
    logic [7:0] mem_m [2][4096];

    ahb_slave_sram #(.BUS_WDT(32), .MEM_AW(10), .WAIT_STATES(0)) u_dut0 (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(sel0), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
        .i_hready(hready0), .o_hready(hready0), .o_hresp(hresp0), .o_hrdata(hrdata0)
    );

    ahb_slave_sram #(.BUS_WDT(32), .MEM_AW(10), .WAIT_STATES(2)) u_dut2 (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(sel2), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
        .i_hready(hready2), .o_hready(hready2), .o_hresp(hresp2), .o_hrdata(hrdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: observed no end, expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic rdy(input int d);
        return (d == 0) ? hready0 : hready2;
    endfunction

    function automatic logic [1:0] rsp(input int d);
        return (d == 0) ? hresp0 : hresp2;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? hrdata0 : hrdata2;
    endfunction

    function automatic logic [31:0] mdl_word(input int d, input logic [31:0] a);
        int b;
        b = int'(a) & 32'hFFC;
        return {mem_m[d][b+3], mem_m[d][b+2], mem_m[d][b+1], mem_m[d][b]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference write: little-endian lanes, only the bytes the size covers.
    task automatic mdl_write(input int d, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int off;
        off = int'(a) % 4;
        for (int i = 0; i < (1 << sz); i++) begin
            mem_m[d][int'(a) + i] = wd[8*(off + i) +: 8];
        end
    endtask

    // One isolated transfer with full response and data checking.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd);
        bit err;
        int ws;
        err = (a >= 32'h1000) || ((a % (32'd1 << sz)) != 0) || (sz > 2'd2);
        ws  = (d == 0) ? 0 : 2;
        @(posedge clk); #1;
        sel0 = (d == 0); sel2 = (d == 1);
        htrans = 2'd2; haddr = a; hwrite = wr; hsize = sz;
        @(posedge clk); #1;
        sel0 = 1'b0; sel2 = 1'b0; htrans = 2'd0; hwdata = wd;
        if (err) begin
            @(negedge clk);
            chk("err1_ready", 32'(rdy(d)), 32'd0);
            chk("err1_resp", 32'(rsp(d)), 32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("err2_ready", 32'(rdy(d)), 32'd1);
            chk("err2_resp", 32'(rsp(d)), 32'd1);
        end else begin
            for (int i = 0; i < ws; i++) begin
                @(negedge clk);
                chk("wait_ready", 32'(rdy(d)), 32'd0);
                chk("wait_resp", 32'(rsp(d)), 32'd0);
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("done_ready", 32'(rdy(d)), 32'd1);
            chk("done_resp", 32'(rsp(d)), 32'd0);
            if (!wr) begin
                chk("read_data", rdat(d), mdl_word(d, a));
            end else begin
                mdl_write(d, a, sz, wd);
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          d, r;
        bit          wr;

        rst_n = 1'b0; sel0 = 1'b0; sel2 = 1'b0; haddr = '0; htrans = 2'd0;
        hwrite = 1'b0; hsize = 2'd0; hwdata = '0;
        for (int i = 0; i < 4096; i++) begin
            mem_m[0][i] = 8'h00;
            mem_m[1][i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 32'(hready0), 32'd1);
        chk("rst_resp0", 32'(hresp0), 32'd0);
        chk("rst_rdata0", hrdata0, 32'd0);
        chk("rst_ready2", 32'(hready2), 32'd1);
        chk("rst_resp2", 32'(hresp2), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Give the working region known contents in both memories.
        for (int w = 0; w < 64; w++) begin
            xfer(0, 1'b1, 32'(w * 4), 2'd2, 32'h0);
            xfer(1, 1'b1, 32'(w * 4), 2'd2, 32'h0);
        end

        // Pipelined write then read of 0x10 on the zero-wait slave.
        @(posedge clk); #1;
        sel0 = 1'b1; htrans = 2'd2; haddr = 32'h10; hwrite = 1'b1; hsize = 2'd2;
        @(posedge clk); #1;
        hwdata = 32'hDEADBEEF; hwrite = 1'b0;
        @(negedge clk);
        chk("b2b_wr_ready", 32'(hready0), 32'd1);
        @(posedge clk); #1;
        sel0 = 1'b0; htrans = 2'd0;
        @(negedge clk);
        chk("b2b_rd_ready", 32'(hready0), 32'd1);
        chk("b2b_rd_data", hrdata0, 32'hDEADBEEF);
        mdl_write(0, 32'h10, 2'd2, 32'hDEADBEEF);

        // Two-wait read of 0x20.
        xfer(1, 1'b1, 32'h20, 2'd2, 32'h5A5AC3C3);
        xfer(1, 1'b0, 32'h20, 2'd2, 32'h0);

        // Single byte into the top lane; other lanes carry junk.
        xfer(0, 1'b1, 32'h10, 2'd2, 32'h00000000);
        xfer(0, 1'b1, 32'h13, 2'd0, 32'hAB5A3C77);
        xfer(0, 1'b0, 32'h10, 2'd2, 32'h0);
        chk("byte_lane_word", mdl_word(0, 32'h10), 32'hAB000000);

        // Error cases leave memory untouched.
        xfer(0, 1'b1, 32'h00, 2'd2, 32'h13579BDF);
        xfer(0, 1'b1, 32'h02, 2'd2, 32'hFFFFFFFF);
        xfer(0, 1'b1, 32'h1000, 2'd2, 32'hEEEEEEEE);
        xfer(0, 1'b1, 32'h08, 2'd3, 32'hDDDDDDDD);
        xfer(1, 1'b1, 32'h1004, 2'd2, 32'hCCCCCCCC);
        xfer(0, 1'b0, 32'h00, 2'd2, 32'h0);
        xfer(0, 1'b0, 32'h08, 2'd2, 32'h0);
        xfer(1, 1'b0, 32'h04, 2'd2, 32'h0);

        // New address phase presented during ERR2 is taken.
        @(posedge clk); #1;
        sel0 = 1'b1; htrans = 2'd2; haddr = 32'h02; hwrite = 1'b1; hsize = 2'd2;
        @(posedge clk); #1;
        sel0 = 1'b0; htrans = 2'd0; hwdata = 32'h99999999;
        @(negedge clk);
        chk("e_err1_ready", 32'(hready0), 32'd0);
        chk("e_err1_resp", 32'(hresp0), 32'd1);
        @(posedge clk); #1;
        sel0 = 1'b1; htrans = 2'd2; haddr = 32'h10; hwrite = 1'b0; hsize = 2'd2;
        @(negedge clk);
        chk("e_err2_ready", 32'(hready0), 32'd1);
        chk("e_err2_resp", 32'(hresp0), 32'd1);
        @(posedge clk); #1;
        sel0 = 1'b0; htrans = 2'd0;
        @(negedge clk);
        chk("e_next_ready", 32'(hready0), 32'd1);
        chk("e_next_resp", 32'(hresp0), 32'd0);
        chk("e_next_data", hrdata0, mdl_word(0, 32'h10));

        // Burst with a BUSY beat and a deselected beat: neither writes.
        @(posedge clk); #1;
        sel0 = 1'b1; htrans = 2'd2; haddr = 32'h40; hwrite = 1'b1; hsize = 2'd2;
        @(posedge clk); #1;
        hwdata = 32'h11111111; htrans = 2'd1; haddr = 32'h4C;
        @(negedge clk);
        chk("burst_w0_ready", 32'(hready0), 32'd1);
        @(posedge clk); #1;
        hwdata = 32'hBAD0BAD0; htrans = 2'd3; haddr = 32'h44;
        @(negedge clk);
        chk("burst_busy_ready", 32'(hready0), 32'd1);
        chk("burst_busy_resp", 32'(hresp0), 32'd0);
        @(posedge clk); #1;
        hwdata = 32'h22222222; sel0 = 1'b0; htrans = 2'd3; haddr = 32'h48;
        @(negedge clk);
        chk("burst_w1_ready", 32'(hready0), 32'd1);
        @(posedge clk); #1;
        hwdata = 32'hBADBAD00; htrans = 2'd0;
        @(negedge clk);
        chk("burst_nosel_ready", 32'(hready0), 32'd1);
        chk("burst_nosel_resp", 32'(hresp0), 32'd0);
        mdl_write(0, 32'h40, 2'd2, 32'h11111111);
        mdl_write(0, 32'h44, 2'd2, 32'h22222222);
        xfer(0, 1'b0, 32'h40, 2'd2, 32'h0);
        xfer(0, 1'b0, 32'h44, 2'd2, 32'h0);
        xfer(0, 1'b0, 32'h48, 2'd2, 32'h0);
        xfer(0, 1'b0, 32'h4C, 2'd2, 32'h0);

        // Reset during the wait states of a write drops the write.
        xfer(1, 1'b1, 32'h30, 2'd2, 32'h12345678);
        @(posedge clk); #1;
        sel2 = 1'b1; htrans = 2'd2; haddr = 32'h30; hwrite = 1'b1; hsize = 2'd2;
        @(posedge clk); #1;
        sel2 = 1'b0; htrans = 2'd0; hwdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstw_wait_ready", 32'(hready2), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstw_async_ready", 32'(hready2), 32'd1);
        chk("rstw_async_resp", 32'(hresp2), 32'd0);
        chk("rstw_async_rdata", hrdata2, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_after_ready", 32'(hready2), 32'd1);
        chk("rstw_after_resp", 32'(hresp2), 32'd0);
        xfer(1, 1'b0, 32'h30, 2'd2, 32'h0);

        // Random mix of sizes, directions, slaves and bad addresses.
        for (int n = 0; n < 200; n++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 15));
            sz = (r == 15) ? 2'd3 : 2'(r % 3);
            a  = 32'($urandom_range(0, 63) * 4);
            r  = int'($urandom_range(0, 15));
            if (r == 0) begin
                a = a + 32'($urandom_range(0, 3));
            end else if (r == 1) begin
                a = a + 32'h1000 * 32'($urandom_range(1, 3));
            end else begin
                a = a + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
            end
            xfer(d, wr, a, sz, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_sram.md
AHB_SLAVE_SRAM -- requirements
Module: ahb_slave_sram

Interface
REQ-001 SHALL have parameter BUS_WDT, default 32; data bus width, legal values 32 or 64.
REQ-002 SHALL have parameter MEM_AW, default 10; log2 of memory depth in bus words.
REQ-003 SHALL have parameter WAIT_STATES, default 0; wait cycles per OKAY transfer, legal range 0..3.
REQ-004 SHALL have port i_hclk, input, 1 bit; clock, all state on rising edge.
REQ-005 SHALL have port i_hreset_n, input, 1 bit; reset, asynchronous, active-low.
REQ-006 SHALL have port i_hsel, input, 1 bit; slave select from the decoder.
REQ-007 SHALL have port i_haddr, input, 32 bits; address-phase address.
REQ-008 SHALL have port i_htrans, input, 2 bits; IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 SHALL have port i_hwrite, input, 1 bit; 1 = write.
REQ-010 SHALL have port i_hsize, input, 2 bits; 0=byte, 1=half, 2=word, 3=dword (dword legal only when BUS_WDT=64).
REQ-011 SHALL have port i_hwdata, input, BUS_WDT bits; write data, data phase.
REQ-012 SHALL have port i_hready, input, 1 bit; bus-level HREADY (previous transfer complete).
REQ-013 SHALL have port o_hready, output, 1 bit; this slave's ready.
REQ-014 SHALL have port o_hresp, output, 2 bits; OKAY=0, ERROR=1. RETRY and SPLIT are never issued.
REQ-015 SHALL have port o_hrdata, output, BUS_WDT bits; read data, valid when o_hready=1 in a read data phase.

Function
REQ-016 SHALL accept an address phase only when i_hsel=1, i_hready=1 and i_htrans is NONSEQ or SEQ, latching addr, write, size.
REQ-017 SHALL treat IDLE or BUSY with i_hsel=1, and any cycle with i_hsel=0, as no transfer; the following data phase is zero-wait OKAY with no memory access.
REQ-018 SHALL implement an FSM with states IDLE, WAIT, ERR1, ERR2.
- IDLE: o_hready=1, o_hresp=OKAY.
- Accepted legal transfer with WAIT_STATES>0: go to WAIT with counter loaded to WAIT_STATES.
- Accepted legal transfer with WAIT_STATES=0: stay in IDLE; the data phase is the next cycle.
REQ-019 SHALL drive o_hready=0 in WAIT and decrement the counter each cycle; at 1 it shall leave WAIT. The following cycle is the completing data-phase cycle with o_hready=1 and OKAY.
REQ-020 SHALL flag an error when any of the following holds, and respond with the two-cycle ERROR sequence (ERR1: hready=0, hresp=ERROR; ERR2: hready=1, hresp=ERROR) with no memory access:
- word index ≥ 2^MEM_AW;
- address not aligned to hsize;
- hsize exceeds bus width.
REQ-021 SHALL accept a new address phase in the cycle ERR2 is driven, only if i_htrans≠IDLE (master may cancel with IDLE per AHB).
REQ-022 SHALL commit a write on the clock edge ending its completing data-phase cycle. Only the byte lanes selected by hsize and low address bits are written; other bytes are unchanged.
REQ-023 SHALL drive o_hrdata from the memory word at the latched address during a read data phase, with all lanes valid; zero otherwise.
REQ-024 SHALL return newly written data on a read immediately following a write to the same address, with no extra wait.
REQ-025 SHALL ignore new address phases while o_hready=0 (i_hready=0 on bus).
REQ-026 SHALL compute the byte index as i_haddr[MEM_AW+log2(BUS_WDT/8)-1:0]. Upper address bits beyond the memory range trigger REQ-020.

Reset
REQ-027 SHALL, on i_hreset_n=0, asynchronously set FSM=IDLE, o_hready=1, o_hresp=OKAY, o_hrdata=0, counter=0, and clear latched transfer valid.
REQ-028 SHALL NOT clear memory contents on reset. A write in progress when reset asserts is dropped.

Structure
REQ-029 SHALL take HTRANS, HRESP and HSIZE encodings from shared package ahb_defs, also used by the master.
REQ-030 SHALL instantiate one sub-module ahb_slave_ram: a 2^MEM_AW x BUS_WDT array with per-byte write enables and an asynchronous read port.
REQ-031 SHALL contain FSM, wait counter, byte-enable generation and error decode in the top module.

Verification
REQ-032 SHALL cover: WAIT_STATES=0, write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> hready stays 1, read returns 0xDEADBEEF.
REQ-033 SHALL cover: WAIT_STATES=2, read 0x20 -> hready low exactly 2 cycles, then 1 with OKAY and data.
REQ-034 SHALL cover: byte write 0xAB to 0x13 after word 0x00000000 at 0x10 -> read 0x10 returns 0xAB000000 (little-endian lanes).
REQ-035 SHALL cover: word access to 0x02 (misaligned) and to 0x1000 with MEM_AW=10 -> ERR1 (hready=0, ERROR), ERR2 (hready=1, ERROR), memory unchanged.
REQ-036 SHALL cover: BUSY or i_hsel=0 interleaved in an INCR burst -> zero-wait OKAY, no write.
REQ-037 SHALL cover: reset asserted during WAIT -> next cycle hready=1, OKAY, FSM IDLE, pending write absent.
